gprs_port_arb: RTL and testbench

Arbiter that shares the register-file write port and the rs1 read port between the pipeline (WB write, DEC rs1 read) and the debug abstract-register path. Debug accesses are serialised through a small FSM with a four-phase req/ack handshake. The pipeline always has priority. An optional starvation limiter forces a WB stall so a pending debug write completes.

---
 rtl/gprs_arb_pkg.sv | 30 +++
 rtl/gprs_arb_starve_cnt.sv | 41 ++++
 rtl/gprs_port_arb.sv | 149 ++++++++++++++
 tb/tb_gprs_port_arb.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gprs_arb_pkg.sv
// Shared types and constants for the GPR port arbiter.
// Latency: n/a (package only).
// Backpressure: n/a.
package gprs_arb_pkg;

  // Debug access sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  // Debug abstract register numbers: x0 maps to REGNO_BASE, x31 to REGNO_LIMIT.
  localparam logic [15:0] REGNO_BASE  = 16'h1000;
  localparam logic [15:0] REGNO_LIMIT = 16'h101f;

  // Width of the starvation counter; STARVE_MAX must fit in it.
  localparam int unsigned STARVE_CNT_W = 4;

  // True when regno addresses one of the 32 GPRs above base. The compare is
  // done one bit wider so a base near 16'hffff cannot wrap the upper bound.
  function automatic logic regno_in_range(input logic [15:0] regno,
                                          input logic [15:0] base);
    logic [16:0] hi;
    hi = {1'b0, base} + 17'd31;
    return (regno >= base) && ({1'b0, regno} <= hi);
  endfunction

endpackage

// File: rtl/gprs_arb_starve_cnt.sv
// Saturating count of write slots the debug path has lost to the pipeline.
// Latency: hit_o is combinational on the increment that reaches MAX.
// Backpressure: none; clr_i wins over inc_i.
module gprs_arb_starve_cnt #(
  parameter int unsigned MAX = 4
) (
  input  logic cpu_clk,
  input  logic cpu_rstn,
  input  logic inc_i,
  input  logic clr_i,
  output logic hit_o
);
  import gprs_arb_pkg::*;

  localparam logic [STARVE_CNT_W-1:0] HIT_AT = STARVE_CNT_W'(MAX - 1);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear has priority, increment saturates at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the lost slot that brings the count up to MAX.
  assign hit_o = inc_i && (cnt_q >= HIT_AT);

endmodule

// File: rtl/gprs_port_arb.sv
// Shares the GPR write port and rs1 read port between pipeline and debug; pipeline has priority.
// Latency: pipeline path is zero-latency pass-through; debug read acks 2 cycles after accept, write >= 2.
// Backpressure: debug four-phase req/ack; optional starvation stall on WB (macro GPRS_ARB_STARVE_EN).
module gprs_port_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [15:0] REGNO_BASE = gprs_arb_pkg::REGNO_BASE,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  wb_wr_valid,
  input  logic [DATA_WIDTH-1:0] wb_wr_data,
  input  logic [4:0]            wb_rd,
  output logic                  wb_stall,
  input  logic [4:0]            dec_rs1,
  output logic                  dec_hold,
  output logic                  gprs_wr_valid,
  output logic [DATA_WIDTH-1:0] gprs_wr_data,
  output logic [4:0]            gprs_rd_wb,
  output logic [4:0]            gprs_rs1,
  input  logic [DATA_WIDTH-1:0] gprs_data1,
  input  logic                  dbg_req,
  input  logic                  dbg_wr1_rd0,
  input  logic [15:0]           dbg_regno,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_ack,
  output logic                  dbg_err,
  output logic [DATA_WIDTH-1:0] dbg_rdata
);
  import gprs_arb_pkg::*;

  arb_state_e            state_q, state_d;
  logic [4:0]            idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  wb_stall_q, wb_stall_d;
  logic                  dbg_win;
  logic                  cnt_hit;

  // The debug write may use the port when the pipeline has nothing to write
  // or is being held off by the starvation stall.
  assign dbg_win = ~wb_wr_valid | wb_stall_q;

`ifdef GPRS_ARB_STARVE_EN
  logic cnt_inc;
  logic cnt_clr;

  // Every WAIT cycle the pipeline wins is a lost slot; the forced-stall
  // cycle itself and the end of a transaction reset the tally.
  assign cnt_inc = (state_q == ST_WAIT) && !dbg_win;
  assign cnt_clr = wb_stall_q || ((state_q == ST_RESP) && !dbg_req);

  gprs_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve_cnt (
    .cpu_clk  (cpu_clk),
    .cpu_rstn (cpu_rstn),
    .inc_i    (cnt_inc),
    .clr_i    (cnt_clr),
    .hit_o    (cnt_hit)
  );
`else
  // Without the limiter a debug write simply waits for an idle WB cycle.
  assign cnt_hit = 1'b0;
`endif

  // Next-state, port muxing and debug capture; pipeline pass-through by default.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    wb_stall_d    = cnt_hit;
    dec_hold      = 1'b0;
    gprs_wr_valid = wb_wr_valid & ~wb_stall_q;
    gprs_wr_data  = wb_wr_data;
    gprs_rd_wb    = wb_rd;
    gprs_rs1      = dec_rs1;

    unique case (state_q)
      ST_IDLE: begin
        if (dbg_req) begin
          idx_d   = dbg_regno[4:0] - REGNO_BASE[4:0];
          wdata_d = dbg_wdata;
          rdata_d = '0;
          if (!regno_in_range(dbg_regno, REGNO_BASE)) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else if (dbg_wr1_rd0) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_XFER;
          end
        end
      end
      ST_XFER: begin
        // Steal the rs1 port for one cycle; a same-cycle WB write to this
        // register is not forwarded, so the old value is captured.
        dec_hold = 1'b1;
        gprs_rs1 = idx_q;
        rdata_d  = gprs_data1;
        state_d  = ST_RESP;
      end
      ST_WAIT: begin
        if (dbg_win) begin
          // x0 is hardwired; the access completes without touching the file.
          gprs_wr_valid = (idx_q != 5'd0);
          gprs_rd_wb    = idx_q;
          gprs_wr_data  = wdata_q;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        if (!dbg_req) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and debug transaction registers.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wb_stall_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wb_stall_q <= wb_stall_d;
    end
  end

  assign wb_stall  = wb_stall_q;
  assign dbg_ack   = (state_q == ST_RESP);
  assign dbg_err   = err_q;
  assign dbg_rdata = rdata_q;

endmodule

// File: tb/tb_gprs_port_arb.sv
// Self-checking bench for gprs_port_arb: vector table, directed corner cases, random traffic.
// Latency: n/a.
// Backpressure: the bench acts as register file and as a pipeline that holds writes under wb_stall.
module tb_gprs_port_arb;

  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          cpu_clk = 1'b0;
  logic          cpu_rstn;
  logic          wb_wr_valid;
  logic [DW-1:0] wb_wr_data;
  logic [4:0]    wb_rd;
  logic          wb_stall;
  logic [4:0]    dec_rs1;
  logic          dec_hold;
  logic          gprs_wr_valid;
  logic [DW-1:0] gprs_wr_data;
  logic [4:0]    gprs_rd_wb;
  logic [4:0]    gprs_rs1;
  logic [DW-1:0] gprs_data1;
  logic          dbg_req;
  logic          dbg_wr1_rd0;
  logic [15:0]   dbg_regno;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic          dbg_err;
  logic [DW-1:0] dbg_rdata;

  int checks = 0;
  int errors = 0;

  gprs_port_arb #(
    .DATA_WIDTH (DW),
    .REGNO_BASE (16'h1000),
    .STARVE_MAX (SMAX)
  ) dut (
    .cpu_clk       (cpu_clk),
    .cpu_rstn      (cpu_rstn),
    .wb_wr_valid   (wb_wr_valid),
    .wb_wr_data    (wb_wr_data),
    .wb_rd         (wb_rd),
    .wb_stall      (wb_stall),
    .dec_rs1       (dec_rs1),
    .dec_hold      (dec_hold),
    .gprs_wr_valid (gprs_wr_valid),
    .gprs_wr_data  (gprs_wr_data),
    .gprs_rd_wb    (gprs_rd_wb),
    .gprs_rs1      (gprs_rs1),
    .gprs_data1    (gprs_data1),
    .dbg_req       (dbg_req),
    .dbg_wr1_rd0   (dbg_wr1_rd0),
    .dbg_regno     (dbg_regno),
    .dbg_wdata     (dbg_wdata),
    .dbg_ack       (dbg_ack),
    .dbg_err       (dbg_err),
    .dbg_rdata     (dbg_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  // Behavioural register file fed by the arbiter's port.
  logic [DW-1:0] rf [32];
  logic          rf_clr;
  int            x0_wr = 0;

  always @(posedge cpu_clk) begin
    if (rf_clr) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (gprs_wr_valid) begin
      if (gprs_rd_wb == 5'd0) x0_wr <= x0_wr + 1;
      else rf[gprs_rd_wb] <= gprs_wr_data;
    end
  end

  assign gprs_data1 = rf[gprs_rs1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    wb_wr_valid = 1'b0;
    wb_wr_data  = '0;
    wb_rd       = '0;
    dec_rs1     = '0;
    dbg_req     = 1'b0;
    dbg_wr1_rd0 = 1'b0;
    dbg_regno   = '0;
    dbg_wdata   = '0;
  endtask

  task automatic dbg_start(input logic wr, input logic [15:0] regno, input logic [31:0] wd);
    dbg_req     = 1'b1;
    dbg_wr1_rd0 = wr;
    dbg_regno   = regno;
    dbg_wdata   = wd;
  endtask

  typedef struct {
    logic        rstn;
    logic        wbv;
    logic [31:0] wdat;
    logic [4:0]  wrd;
    logic [4:0]  rs1;
    logic        e_gv;
    logic [31:0] e_gdat;
    logic [4:0]  e_grd;
    logic [4:0]  e_rs1;
  } vec_t;

  vec_t vecs[6];

  // Random-phase reference state.
  logic [31:0] model [32];
  logic        pv;
  logic [4:0]  prd;
  logic [31:0] pdata;
  int          phase;
  logic        last_ack;
  logic        t_wr;
  logic [15:0] t_regno;
  logic [31:0] t_wdata;
  logic [4:0]  t_idx;
  int          t_cnt;
  logic        t_err;
  bit          done;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //            rstn wbv  wdat          wrd    rs1    gv   gdat          grd    rs1
    vecs[0] = '{1'b0, 1'b0, 32'h0,        5'd0,  5'd0,  1'b0, 32'h0,        5'd0,  5'd0};
    vecs[1] = '{1'b0, 1'b0, 32'h0,        5'd0,  5'd9,  1'b0, 32'h0,        5'd0,  5'd9};
    vecs[2] = '{1'b1, 1'b1, 32'h12345678, 5'd3,  5'd3,  1'b1, 32'h12345678, 5'd3,  5'd3};
    vecs[3] = '{1'b1, 1'b0, 32'h0000dead, 5'd4,  5'd31, 1'b0, 32'h0000dead, 5'd4,  5'd31};
    vecs[4] = '{1'b1, 1'b1, 32'hffffffff, 5'd31, 5'd0,  1'b1, 32'hffffffff, 5'd31, 5'd0};
    vecs[5] = '{1'b1, 1'b1, 32'h00000001, 5'd17, 5'd17, 1'b1, 32'h00000001, 5'd17, 5'd17};

    cpu_rstn = 1'b0;
    rf_clr   = 1'b1;
    idle_inputs();
    repeat (2) @(negedge cpu_clk);
    rf_clr = 1'b0;

    // Reset state and IDLE pass-through.
    foreach (vecs[v]) begin
      @(negedge cpu_clk);
      cpu_rstn    = vecs[v].rstn;
      wb_wr_valid = vecs[v].wbv;
      wb_wr_data  = vecs[v].wdat;
      wb_rd       = vecs[v].wrd;
      dec_rs1     = vecs[v].rs1;
      #1;
      chk($sformatf("vec%0d_gv", v), gprs_wr_valid, vecs[v].e_gv);
      chk($sformatf("vec%0d_gdat", v), gprs_wr_data, vecs[v].e_gdat);
      chk($sformatf("vec%0d_grd", v), gprs_rd_wb, vecs[v].e_grd);
      chk($sformatf("vec%0d_rs1", v), gprs_rs1, vecs[v].e_rs1);
      chk($sformatf("vec%0d_stall", v), wb_stall, 0);
      chk($sformatf("vec%0d_hold", v), dec_hold, 0);
      chk($sformatf("vec%0d_ack", v), dbg_ack, 0);
      chk($sformatf("vec%0d_err", v), dbg_err, 0);
      chk($sformatf("vec%0d_rdata", v), dbg_rdata, 0);
    end
    @(negedge cpu_clk);
    idle_inputs();

    // Debug write x5, WB idle.
    @(negedge cpu_clk); dbg_start(1'b1, 16'h1005, 32'hdeadbeef); #1;
    chk("wr5_ack_accept", dbg_ack, 0);
    @(negedge cpu_clk); #1;
    chk("wr5_gv", gprs_wr_valid, 1);
    chk("wr5_grd", gprs_rd_wb, 5);
    chk("wr5_gdat", gprs_wr_data, 32'hdeadbeef);
    chk("wr5_ack_early", dbg_ack, 0);
    @(negedge cpu_clk); #1;
    chk("wr5_ack", dbg_ack, 1);
    chk("wr5_err", dbg_err, 0);
    chk("wr5_rf", rf[5], 32'hdeadbeef);
    dbg_req = 1'b0; #1;
    chk("wr5_ack_hold", dbg_ack, 1);
    @(negedge cpu_clk); #1;
    chk("wr5_ack_drop", dbg_ack, 0);

    // Debug read x3 (written by the vector table).
    @(negedge cpu_clk); dbg_start(1'b0, 16'h1003, 32'h0); dec_rs1 = 5'd9; #1;
    chk("rd3_hold_accept", dec_hold, 0);
    @(negedge cpu_clk); #1;
    chk("rd3_hold", dec_hold, 1);
    chk("rd3_rs1", gprs_rs1, 3);
    @(negedge cpu_clk); #1;
    chk("rd3_hold_after", dec_hold, 0);
    chk("rd3_rs1_pass", gprs_rs1, 9);
    chk("rd3_ack", dbg_ack, 1);
    chk("rd3_rdata", dbg_rdata, 32'h12345678);
    dbg_req = 1'b0;
    @(negedge cpu_clk); #1;
    chk("rd3_ack_drop", dbg_ack, 0);

    // Out-of-range regno.
    @(negedge cpu_clk); dbg_start(1'b1, 16'h1020, 32'h55555555); #1;
    chk("oor_hold0", dec_hold, 0);
    @(negedge cpu_clk); #1;
    chk("oor_ack", dbg_ack, 1);
    chk("oor_err", dbg_err, 1);
    chk("oor_hold1", dec_hold, 0);
    chk("oor_gv", gprs_wr_valid, 0);
    dbg_req = 1'b0;
    @(negedge cpu_clk); #1;
    chk("oor_ack_drop", dbg_ack, 0);
    chk("oor_err_clr", dbg_err, 0);

    // Debug write x7 against a continuously writing pipeline.
    @(negedge cpu_clk);
    wb_wr_valid = 1'b1; wb_rd = 5'd20; wb_wr_data = 32'haaaa0014;
    dbg_start(1'b1, 16'h1007, 32'h77777777); #1;
`ifdef GPRS_ARB_STARVE_EN
    for (int i = 1; i <= SMAX; i++) begin
      @(negedge cpu_clk); #1;
      chk($sformatf("starve_w%0d_stall", i), wb_stall, 0);
      chk($sformatf("starve_w%0d_grd", i), gprs_rd_wb, 20);
    end
    @(negedge cpu_clk); #1;
    chk("starve_stall", wb_stall, 1);
    chk("starve_gv", gprs_wr_valid, 1);
    chk("starve_grd", gprs_rd_wb, 7);
    chk("starve_gdat", gprs_wr_data, 32'h77777777);
    @(negedge cpu_clk); #1;
    chk("starve_stall_fall", wb_stall, 0);
    chk("starve_ack", dbg_ack, 1);
    chk("starve_pipe_gv", gprs_wr_valid, 1);
    chk("starve_pipe_grd", gprs_rd_wb, 20);
    wb_wr_valid = 1'b0; dbg_req = 1'b0;
`else
    for (int i = 1; i <= 10; i++) begin
      @(negedge cpu_clk); #1;
      chk($sformatf("nostarve_w%0d_grd", i), gprs_rd_wb, 20);
      chk($sformatf("nostarve_w%0d_ack", i), dbg_ack, 0);
    end
    @(negedge cpu_clk); wb_wr_valid = 1'b0; #1;
    chk("nostarve_gv", gprs_wr_valid, 1);
    chk("nostarve_grd", gprs_rd_wb, 7);
    chk("nostarve_gdat", gprs_wr_data, 32'h77777777);
    @(negedge cpu_clk); #1;
    chk("nostarve_ack", dbg_ack, 1);
    dbg_req = 1'b0;
`endif
    @(negedge cpu_clk); #1;
    chk("starve_rf7", rf[7], 32'h77777777);
    chk("starve_rf20", rf[20], 32'haaaa0014);
    chk("starve_ack_drop", dbg_ack, 0);

    // Debug write to x0.
    @(negedge cpu_clk); dbg_start(1'b1, 16'h1000, 32'h0bad0000); #1;
    @(negedge cpu_clk); #1;
    chk("x0_gv", gprs_wr_valid, 0);
    @(negedge cpu_clk); #1;
    chk("x0_ack", dbg_ack, 1);
    chk("x0_err", dbg_err, 0);
    dbg_req = 1'b0;
    @(negedge cpu_clk); #1;
    chk("x0_ack_drop", dbg_ack, 0);

    // Reset in the middle of a pending write.
    @(negedge cpu_clk);
    wb_wr_valid = 1'b1; wb_rd = 5'd21; wb_wr_data = 32'h00000021;
    dbg_start(1'b1, 16'h1009, 32'h99990009);
    @(negedge cpu_clk);
    @(negedge cpu_clk);
    cpu_rstn = 1'b0; idle_inputs(); #1;
    chk("rst_ack", dbg_ack, 0);
    chk("rst_err", dbg_err, 0);
    chk("rst_rdata", dbg_rdata, 0);
    chk("rst_stall", wb_stall, 0);
    chk("rst_hold", dec_hold, 0);
    chk("rst_gv", gprs_wr_valid, 0);
    @(negedge cpu_clk); cpu_rstn = 1'b1; #1;
    chk("rst_no_partial", rf[9], 0);
    chk("rst_idle_ack", dbg_ack, 0);
    @(negedge cpu_clk); dbg_start(1'b1, 16'h1009, 32'h99990009);
    @(negedge cpu_clk); #1;
    chk("post_rst_gv", gprs_wr_valid, 1);
    chk("post_rst_grd", gprs_rd_wb, 9);
    @(negedge cpu_clk); #1;
    chk("post_rst_ack", dbg_ack, 1);
    dbg_req = 1'b0;
    @(negedge cpu_clk); #1;
    chk("post_rst_rf9", rf[9], 32'h99990009);

    // Random traffic: pipeline writes x16..x31, debug touches x0..x15 or out-of-range.
    rf_clr = 1'b1;
    @(negedge cpu_clk);
    rf_clr = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    pv = 1'b0; prd = '0; pdata = '0;
    phase = 0; last_ack = 1'b0; t_cnt = 0; t_idx = '0;
    t_wr = 1'b0; t_regno = '0; t_wdata = '0; t_err = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge cpu_clk);
      if (!pv && c < 3000 && $urandom_range(0, 9) < 6) begin
        pv    = 1'b1;
        prd   = 5'(16 + $urandom_range(0, 15));
        pdata = $urandom;
      end
      wb_wr_valid = pv;
      wb_rd       = prd;
      wb_wr_data  = pdata;
      dec_rs1     = 5'($urandom_range(0, 31));
      if (phase == 0 && !last_ack && c < 3000 && $urandom_range(0, 3) == 0) begin
        t_wr    = 1'($urandom_range(0, 1));
        t_wdata = $urandom;
        case ($urandom_range(0, 3))
          0: t_regno = 16'($urandom_range(0, 16'h0fff));
          1: t_regno = 16'($urandom_range(16'h1020, 16'hffff));
          default: t_regno = 16'h1000 + 16'($urandom_range(0, 15));
        endcase
        t_err = (t_regno < 16'h1000) || (t_regno > 16'h101f);
        t_idx = 5'(t_regno - 16'h1000);
        t_cnt = 0;
        phase = 1;
      end
      dbg_req     = (phase == 1);
      dbg_wr1_rd0 = t_wr;
      dbg_regno   = t_regno;
      dbg_wdata   = t_wdata;
      #1;
      if (dec_hold) chk("rnd_rs1_dbg", gprs_rs1, t_idx);
      else chk("rnd_rs1_pass", gprs_rs1, dec_rs1);
      if (wb_wr_valid && !wb_stall) begin
        model[prd] = pdata;
        pv = 1'b0;
      end
      if (phase == 1) begin
        if (dbg_ack) begin
          chk("rnd_err", dbg_err, t_err);
          if (!t_wr && !t_err) chk("rnd_rdata", dbg_rdata, model[t_idx]);
          if (t_wr && !t_err && t_idx != 5'd0) model[t_idx] = t_wdata;
          phase = 2;
        end else begin
          t_cnt++;
          if (t_cnt > 200) begin
            checks++;
            errors++;
            $display("FAIL rnd_ack_timeout: no ack after %0d cycles for regno 0x%04h", t_cnt, t_regno);
            phase = 2;
          end
        end
      end else if (phase == 2 && !dbg_ack) begin
        phase = 0;
      end
      last_ack = dbg_ack;
      if (c >= 3000 && phase == 0 && !pv) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rnd_drain: traffic still pending, phase %0d pending_wb %0d", phase, pv);
    end
    @(negedge cpu_clk);
    idle_inputs();
    @(negedge cpu_clk); #1;
    for (int i = 0; i < 32; i++) chk($sformatf("rnd_rf_x%0d", i), rf[i], model[i]);
    chk("x0_write_count", 32'(x0_wr), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
